// File: rtl/picomips_pkg.sv
// picomips_pkg: opcode/state enums, ALU and source-select codes, instruction field positions
package picomips_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_ADDI = 3'b010,
        OP_MULI = 3'b011,
        OP_JMP  = 3'b100,
        OP_BEQ  = 3'b101,
        OP_WAIT = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_EXEC    = 2'b01,
        S_WAIT_IN = 2'b10,
        S_HALT    = 2'b11
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_MUL  = 2'b10;
    localparam logic [1:0] ALU_SUB  = 2'b11;

    localparam logic [1:0] SRC_REG = 2'b00;
    localparam logic [1:0] SRC_IMM = 2'b01;
    localparam logic [1:0] SRC_IN  = 2'b10;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS_MSB  = 9;
    localparam int RS_LSB  = 7;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: program-memory, PC command, input-port handshake and datapath control bundle
interface pc_sequencer_if #(
    parameter int Psize = 6,
    parameter int Isize = 16,
    parameter int Rsize = 3
);
    logic [Isize-1:0] instr;
    logic             alu_zero;
    logic             in_valid;
    logic             in_ready;
    logic             PCincr;
    logic             PCload;
    logic [Psize-1:0] PCtarget;
    logic             reg_we;
    logic [Rsize-1:0] rd;
    logic [Rsize-1:0] rs;
    logic [6:0]       imm;
    logic [1:0]       alu_op;
    logic [1:0]       src_sel;
    logic             halted;

    modport master (
        input  instr, alu_zero, in_valid,
        output in_ready, PCincr, PCload, PCtarget, reg_we, rd, rs, imm, alu_op, src_sel, halted
    );

    modport slave (
        output instr, alu_zero, in_valid,
        input  in_ready, PCincr, PCload, PCtarget, reg_we, rd, rs, imm, alu_op, src_sel, halted
    );
endinterface

// File: rtl/pc_sequencer_instr_decoder.sv
// instr_decoder: maps the held instruction and sequencer state to register/ALU/source controls
module instr_decoder
    import picomips_pkg::*;
#(
    parameter int Isize = 16,
    parameter int Rsize = 3
) (
    input  logic [Isize-1:0] i_ir,
    input  state_t           i_state,
    output logic [Rsize-1:0] o_rd,
    output logic [Rsize-1:0] o_rs,
    output logic [6:0]       o_imm,
    output logic [1:0]       o_alu_op,
    output logic [1:0]       o_src_sel
);
    logic    w_act;
    opcode_t w_op;

    assign w_act = (i_state == S_EXEC) || (i_state == S_WAIT_IN);
    assign w_op  = opcode_t'(i_ir[OP_MSB:OP_LSB]);

    // Fields are only driven while an instruction is executing; FETCH and HALT present zeros
    always_comb begin
        o_rd      = w_act ? i_ir[RD_MSB:RD_LSB] : '0;
        o_rs      = w_act ? i_ir[RS_MSB:RS_LSB] : '0;
        o_imm     = w_act ? i_ir[IMM_MSB:IMM_LSB] : '0;
        o_alu_op  = !w_act ? ALU_PASS :
                    (w_op == OP_ADD || w_op == OP_ADDI) ? ALU_ADD :
                    (w_op == OP_MULI) ? ALU_MUL :
                    (w_op == OP_BEQ) ? ALU_SUB : ALU_PASS;
        o_src_sel = !w_act ? SRC_REG :
                    (w_op == OP_ADDI || w_op == OP_MULI) ? SRC_IMM :
                    (w_op == OP_WAIT) ? SRC_IN : SRC_REG;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle FETCH/EXEC/WAIT_IN/HALT control sequencer for the picoMIPS core
module pc_sequencer
    import picomips_pkg::*;
#(
    parameter int Psize = 6,
    parameter int Isize = 16,
    parameter int Rsize = 3
) (
    input logic          clk,
    input logic          reset,
    pc_sequencer_if.master bus
);
    state_t           r_state;
    state_t           w_next;
    state_t           w_dec_state;
    logic [Isize-1:0] r_ir;
    opcode_t          w_op;
    logic             w_incr;
    logic             w_load;
    logic             w_we;
    logic             w_ready;
    logic [6:0]       w_imm;

    assign w_op = opcode_t'(r_ir[OP_MSB:OP_LSB]);

    // State and instruction register; IR captures program memory only in FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) r_ir <= bus.instr;
        end
    end

    // Next-state and pulse generation; pulses are qualified by reset below
    always_comb begin
        w_next  = r_state;
        w_incr  = 1'b0;
        w_load  = 1'b0;
        w_we    = 1'b0;
        w_ready = 1'b0;
        case (r_state)
            S_FETCH: w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_op)
                    OP_NOP: w_incr = 1'b1;
                    OP_ADD, OP_ADDI, OP_MULI: begin
                        w_we   = 1'b1;
                        w_incr = 1'b1;
                    end
                    OP_JMP: w_load = 1'b1;
                    OP_BEQ: begin
                        w_load = bus.alu_zero;
                        w_incr = !bus.alu_zero;
                    end
                    OP_WAIT: w_next = S_WAIT_IN;
                    default: w_next = S_HALT;
                endcase
            end
            S_WAIT_IN: begin
                w_ready = 1'b1;
                w_we    = bus.in_valid;
                w_incr  = bus.in_valid;
                w_next  = bus.in_valid ? S_FETCH : S_WAIT_IN;
            end
            default: w_next = S_HALT;
        endcase
    end

    // Reset forces every output to zero in the same cycle, even mid-handshake or halted
    assign w_dec_state  = reset ? S_FETCH : r_state;
    assign bus.PCincr   = !reset && w_incr;
    assign bus.PCload   = !reset && w_load;
    assign bus.reg_we   = !reset && w_we;
    assign bus.in_ready = !reset && w_ready;
    assign bus.halted   = (w_dec_state == S_HALT);
    assign bus.imm      = w_imm;
    assign bus.PCtarget = w_imm[Psize-1:0];

    instr_decoder #(
        .Isize(Isize),
        .Rsize(Rsize)
    ) u_dec (
        .i_ir     (r_ir),
        .i_state  (w_dec_state),
        .o_rd     (bus.rd),
        .o_rs     (bus.rs),
        .o_imm    (w_imm),
        .o_alu_op (bus.alu_op),
        .o_src_sel(bus.src_sel)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for the picoMIPS control sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;

    pc_sequencer_if #(.Psize(6), .Isize(16), .Rsize(3)) bus ();

    pc_sequencer #(.Psize(6), .Isize(16), .Rsize(3)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // {reg_we, PCincr, PCload, in_ready, halted, rd, rs, imm, alu_op, src_sel}
    logic [21:0] obs;
    assign obs = {bus.reg_we, bus.PCincr, bus.PCload, bus.in_ready, bus.halted,
                  bus.rd, bus.rs, bus.imm, bus.alu_op, bus.src_sel};

    localparam logic [21:0] ALL_ZERO = 22'd0;
    localparam logic [21:0] NOP_EXEC = {5'b01000, 3'd0, 3'd0, 7'd0, 2'b00, 2'b00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instr = 16'h0000;
        bus.alu_zero = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (obs !== ALL_ZERO || bus.PCtarget !== 6'd0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %h/%h want 0", i, obs, bus.PCtarget);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs !== ALL_ZERO) begin
                n_fail++;
                $display("FAIL nop_fetch %0d: got %h want %h", i, obs, ALL_ZERO);
            end
            tick();
            n_chk++;
            if (obs !== NOP_EXEC) begin
                n_fail++;
                $display("FAIL nop_exec %0d: got %h want %h", i, obs, NOP_EXEC);
            end
            tick();
        end
    endtask

    task automatic test_alu_ops();
        logic [15:0] ins [3];
        logic [21:0] exp [3];
        ins[0] = 16'h4505; exp[0] = {5'b11000, 3'd1, 3'd2, 7'd5, 2'b01, 2'b01};
        ins[1] = 16'h2E80; exp[1] = {5'b11000, 3'd3, 3'd5, 7'd0, 2'b01, 2'b00};
        ins[2] = 16'h7003; exp[2] = {5'b11000, 3'd4, 3'd0, 7'd3, 2'b10, 2'b01};
        for (int i = 0; i < 3; i++) begin
            bus.instr = ins[i];
            #1;
            n_chk++;
            if (obs !== ALL_ZERO) begin
                n_fail++;
                $display("FAIL alu_fetch %h: got %h want %h", ins[i], obs, ALL_ZERO);
            end
            tick();
            bus.instr = 16'h0000;
            #1;
            n_chk++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("FAIL alu_exec %h: got %h want %h", ins[i], obs, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_jumps();
        bus.instr = 16'h8012;
        tick();
        bus.instr = 16'h0000;
        #1;
        n_chk++;
        if (obs !== {5'b00100, 3'd0, 3'd0, 7'd18, 2'b00, 2'b00} || bus.PCtarget !== 6'd18) begin
            n_fail++;
            $display("FAIL jmp_exec: got %h tgt %0d want load tgt 18", obs, bus.PCtarget);
        end
        tick();
        bus.instr = 16'hA413;
        bus.alu_zero = 1'b1;
        tick();
        #1;
        n_chk++;
        if (obs !== {5'b00100, 3'd1, 3'd0, 7'd19, 2'b11, 2'b00} || bus.PCtarget !== 6'd19) begin
            n_fail++;
            $display("FAIL beq_taken: got %h tgt %0d want load tgt 19", obs, bus.PCtarget);
        end
        bus.alu_zero = 1'b0;
        #1;
        n_chk++;
        if (obs !== {5'b01000, 3'd1, 3'd0, 7'd19, 2'b11, 2'b00}) begin
            n_fail++;
            $display("FAIL beq_not_taken: got %h want incr only", obs);
        end
        tick();
    endtask

    task automatic test_wait();
        int rdy_cycles = 0;
        bus.instr = 16'hC800;
        bus.in_valid = 1'b0;
        tick();
        n_chk++;
        if (obs !== {5'b00000, 3'd2, 3'd0, 7'd0, 2'b00, 2'b10}) begin
            n_fail++;
            $display("FAIL wait_exec: got %h want no pulses", obs);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            rdy_cycles += int'(bus.in_ready);
            n_chk++;
            if (obs !== {5'b00010, 3'd2, 3'd0, 7'd0, 2'b00, 2'b10}) begin
                n_fail++;
                $display("FAIL wait_idle %0d: got %h want ready only", i, obs);
            end
            tick();
        end
        bus.in_valid = 1'b1;
        #1;
        rdy_cycles += int'(bus.in_ready);
        n_chk++;
        if (obs !== {5'b11010, 3'd2, 3'd0, 7'd0, 2'b00, 2'b10}) begin
            n_fail++;
            $display("FAIL wait_accept: got %h want we/incr/ready", obs);
        end
        n_chk++;
        if (rdy_cycles != 6) begin
            n_fail++;
            $display("FAIL wait_ready_cycles: got %0d want 6", rdy_cycles);
        end
        tick();
        n_chk++;
        if (obs !== ALL_ZERO) begin
            n_fail++;
            $display("FAIL wait_back_to_fetch: got %h want 0", obs);
        end
        tick();
        n_chk++;
        if (obs !== {5'b00000, 3'd2, 3'd0, 7'd0, 2'b00, 2'b10}) begin
            n_fail++;
            $display("FAIL wait_early_exec: got %h want no pulses", obs);
        end
        tick();
        n_chk++;
        if (obs !== {5'b11010, 3'd2, 3'd0, 7'd0, 2'b00, 2'b10}) begin
            n_fail++;
            $display("FAIL wait_early_accept: got %h want we/incr/ready", obs);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        bus.instr = 16'hC800;
        tick();
        tick();
        bus.in_valid = 1'b1;
        reset = 1'b1;
        #1;
        n_chk++;
        if (obs !== ALL_ZERO) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %h want 0", obs);
        end
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr = 16'h0000;
        #1;
        n_chk++;
        if (obs !== ALL_ZERO) begin
            n_fail++;
            $display("FAIL reset_wait_fetch: got %h want 0", obs);
        end
        tick();
        n_chk++;
        if (obs !== NOP_EXEC) begin
            n_fail++;
            $display("FAIL reset_wait_resume: got %h want %h", obs, NOP_EXEC);
        end
        tick();
    endtask

    task automatic test_halt();
        int bad = 0;
        bus.instr = 16'hE000;
        tick();
        bus.instr = 16'h0000;
        #1;
        n_chk++;
        if (obs !== ALL_ZERO) begin
            n_fail++;
            $display("FAIL halt_exec: got %h want 0", obs);
        end
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.alu_zero = i[1];
            #1;
            if (obs !== {5'b00001, 17'd0}) bad++;
            tick();
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL halt_hold: %0d bad cycles want 0", bad);
        end
        bus.in_valid = 1'b0;
        bus.alu_zero = 1'b0;
        reset = 1'b1;
        tick();
        n_chk++;
        if (bus.halted !== 1'b0 || obs !== ALL_ZERO) begin
            n_fail++;
            $display("FAIL halt_reset: got %h want 0", obs);
        end
        reset = 1'b0;
        tick();
        n_chk++;
        if (obs !== NOP_EXEC) begin
            n_fail++;
            $display("FAIL halt_resume: got %h want %h", obs, NOP_EXEC);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_jumps();
        test_wait();
        test_reset_in_wait();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control sequencer for the picoMIPS core. It is the controlling end of the program-counter interface: it drives increment/load commands to the PC, reads the instruction at the current PC from program memory, decodes it, and issues register-file and ALU controls. It also performs a ready/valid handshake with the switch/input port for WAIT instructions, and stops the core on HALT.

Parameters:
Psize, 6, program-address width; must match the PC; Psize <= Isize-9
Isize, 16, instruction width; fields fixed as below for Isize=16
Rsize, 3, register-index width

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high; sampled on posedge clk only
instr  input  Isize  program-memory read data at the current PC (combinational ROM)
alu_zero  input  1  ALU result == 0, valid during EXEC
in_valid  input  1  input port holds a valid value
in_ready  output  1  sequencer accepts the input value (WAIT state only)
PCincr  output  1  one-cycle pulse: PC <= PC+1
PCload  output  1  one-cycle pulse: PC <= PCtarget; never high together with PCincr
PCtarget  output  Psize  branch/jump target
reg_we  output  1  register-file write enable, one-cycle pulse
rd  output  Rsize  destination register index
rs  output  Rsize  source register index
imm  output  7  immediate field
alu_op  output  2  00 pass, 01 add, 10 mul, 11 sub (compare)
src_sel  output  2  00 register, 01 immediate, 10 input port
halted  output  1  high in HALT

Behaviour:
- Instruction fields: op=instr[15:13], rd=[12:10], rs=[9:7], imm=[6:0]; PCtarget=imm[Psize-1:0].
- Opcodes: 000 NOP, 001 ADD rd+=rs, 010 ADDI rd+=imm, 011 MULI rd*=imm, 100 JMP, 101 BEQ (jump if rd==rs), 110 WAIT (rd<=input), 111 HALT.
- States: FETCH, EXEC, WAIT_IN, HALT. Reset -> FETCH. On reset, every output is 0, and IR is cleared to 0 (NOP).
- FETCH: IR <= instr; all pulse outputs 0; next state EXEC. Each instruction takes 2 cycles; WAIT takes 2+N cycles.
- EXEC: rd/rs/imm/alu_op/src_sel are decoded combinationally from IR.
  - NOP: PCincr=1.
  - ADD/ADDI/MULI: reg_we=1, PCincr=1.
  - JMP: PCload=1.
  - BEQ: alu_op=11; alu_zero=1 -> PCload=1, otherwise PCincr=1; reg_we=0.
  - Next state is FETCH for all of the above.
  - WAIT: no pulses; next state WAIT_IN.
  - HALT: no pulses; next state HALT.
- WAIT_IN: in_ready=1; src_sel=10; rd is held.
  - When in_valid=1 in the same cycle: reg_we=1, PCincr=1, next state FETCH.
  - Otherwise stay in WAIT_IN with no pulses.
  - in_valid already high on entry completes in the first WAIT_IN cycle.
- HALT: halted=1; no pulses; in_ready=0; exit only by reset.
- PCincr and PCload are mutually exclusive and high for exactly one cycle per non-WAIT/non-HALT instruction.
- PC wrap-around at 2^Psize-1 belongs to the PC; the sequencer does not detect it.
- Reset has priority over everything in any state, including mid-WAIT handshake and HALT: no pulse is issued in the reset cycle, and the next state is FETCH.

Decomposition:
- Shared package picomips_pkg:
  - opcode enum (3 bits)
  - state enum
  - alu_op and src_sel constants
  - field bit-position localparams
- Natural sub-module: instr_decoder. It is combinational, maps IR and state to rd/rs/imm/alu_op/src_sel. The FSM and IR register stay in pc_sequencer.

Test Plan:
- Reset held 2 cycles, then release with instr=0x0000 (NOP) -> all outputs 0 during reset; PCincr=1 exactly on the 2nd cycle after release; repeats every 2 cycles.
- instr=0x4505 (ADDI rd=1 imm=5) -> in EXEC: reg_we=1, rd=1, imm=5, alu_op=01, src_sel=01, PCincr=1, PCload=0.
- instr=0x8012 (JMP 18): PCload=1, PCtarget=18, PCincr=0. instr=0xA000 BEQ: with alu_zero=1 -> PCload=1; with alu_zero=0 -> PCincr=1 only.
- instr=0xC800 (WAIT rd=2), in_valid low 5 cycles then high -> in_ready=1 for 6 cycles; reg_we=1, rd=2, src_sel=10, and PCincr=1 all in the in_valid cycle; then FETCH.
- instr=0xE000 (HALT) -> halted=1 indefinitely, no PCincr/PCload for 20 cycles; reset asserted -> halted=0 next cycle, FETCH.
- Reset asserted during WAIT_IN with in_valid=1 -> no reg_we/PCincr in that cycle; state FETCH after reset; in_ready=0.
